// File: rtl/testmasterslave6_types.sv
// Shared types for the TestMasterSlave6 producer/consumer pair.
// Holds the producer section encoding and the common word widths.
package testmasterslave6_types;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        prod_read  = 2'd0,
        prod_write = 2'd1,
        prod_gap   = 2'd2
    } ProdSections;

endpackage

// File: rtl/tms6_accumulating_producer.sv
// Accumulating producer: running signed frame sum, published as data + one-cycle sync pulse.
// Latency 1 cycle from sample transfer to m_out/m_out_sync; b_in_notify drops for 1+GAP cycles after each transfer.
module tms6_accumulating_producer
    import testmasterslave6_types::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int GAP       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic                     b_in_sync,
    output logic                     b_in_notify,
    output logic signed [DATA_W-1:0] m_out,
    output logic                     m_out_sync
);

    if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
        $error("FRAME_LEN must be in 1..255");
    end
    if (GAP < 0 || GAP > 255) begin : g_bad_gap
        $error("GAP must be in 0..255");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    ProdSections              section, section_nxt;
    logic signed [DATA_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [CNT_W-1:0]         gap_cnt, gap_cnt_nxt;
    logic                     notify_nxt;
    logic signed [DATA_W-1:0] m_out_nxt;
    logic                     sync_nxt;
    logic signed [DATA_W-1:0] sum;

    // Two's complement add wraps naturally at 32 bits.
    assign sum = acc + b_in;

    always_comb begin
        section_nxt = section;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        gap_cnt_nxt = gap_cnt;
        notify_nxt  = b_in_notify;
        m_out_nxt   = m_out;
        sync_nxt    = 1'b0;
        case (section)
            prod_read: begin
                if (b_in_notify && b_in_sync) begin
                    m_out_nxt   = sum;
                    sync_nxt    = 1'b1;
                    notify_nxt  = 1'b0;
                    section_nxt = prod_write;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt = '0;
                        acc_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        acc_nxt = sum;
                    end
                end
            end
            prod_write: begin
                if (GAP == 0) begin
                    section_nxt = prod_read;
                    notify_nxt  = 1'b1;
                end else begin
                    section_nxt = prod_gap;
                    gap_cnt_nxt = GAP_LAST;
                end
            end
            prod_gap: begin
                if (gap_cnt == '0) begin
                    section_nxt = prod_read;
                    notify_nxt  = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                section_nxt = prod_read;
                notify_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section     <= prod_read;
            b_in_notify <= 1'b1;
            m_out       <= '0;
            m_out_sync  <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            gap_cnt     <= '0;
        end else begin
            section     <= section_nxt;
            b_in_notify <= notify_nxt;
            m_out       <= m_out_nxt;
            m_out_sync  <= sync_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tms6_accumulating_producer.sv
// Bench for the accumulating producer: one instance with FRAME_LEN=4/GAP=0, one with FRAME_LEN=1/GAP=2.
module tb_tms6_accumulating_producer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] b_in0 = '0, b_in2 = '0;
    logic               b_in_sync0 = 1'b0, b_in_sync2 = 1'b0;
    logic               notify0, notify2;
    logic signed [31:0] m_out0, m_out2;
    logic               sync0, sync2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame sum per instance, plain arithmetic.
    int          frame_len [2] = '{4, 1};
    logic [31:0] m_acc [2];
    int          m_cnt [2];

    always #5 clk = ~clk;

    tms6_accumulating_producer #(.FRAME_LEN(4), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .b_in(b_in0), .b_in_sync(b_in_sync0),
        .b_in_notify(notify0), .m_out(m_out0), .m_out_sync(sync0)
    );

    tms6_accumulating_producer #(.FRAME_LEN(1), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .b_in(b_in2), .b_in_sync(b_in_sync2),
        .b_in_notify(notify2), .m_out(m_out2), .m_out_sync(sync2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = '0;
            m_cnt[i] = 0;
        end
    endtask

    function automatic logic [31:0] model_sum(input int id, input logic [31:0] v);
        return m_acc[id] + v;
    endfunction

    task automatic model_commit(input int id, input logic [31:0] v);
        logic [31:0] s;
        s = m_acc[id] + v;
        if (m_cnt[id] == frame_len[id] - 1) begin
            m_acc[id] = '0;
            m_cnt[id] = 0;
        end else begin
            m_acc[id] = s;
            m_cnt[id]++;
        end
    endtask

    task automatic wait_notify(input int id);
        int k = 0;
        while (((id == 0) ? notify0 : notify2) !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("notify_wait", {31'd0, (id == 0) ? notify0 : notify2}, 32'd1);
    endtask

    // GAP=0 instance: notify low for exactly one cycle, pulse one cycle after transfer.
    task automatic send0(input logic [31:0] v, input logic [31:0] exp);
        wait_notify(0);
        b_in0 = v;
        b_in_sync0 = 1'b1;
        model_commit(0, v);
        @(negedge clk);
        chk("pub0_data", m_out0, exp);
        chk("pub0_sync", {31'd0, sync0}, 32'd1);
        chk("pub0_notify_low", {31'd0, notify0}, 32'd0);
        b_in_sync0 = 1'b0;
        @(negedge clk);
        chk("pub0_sync_drop", {31'd0, sync0}, 32'd0);
        chk("pub0_notify_back", {31'd0, notify0}, 32'd1);
        chk("pub0_hold", m_out0, exp);
    endtask

    // GAP=2 instance: a sync pulse inside the gap must be ignored.
    task automatic send2(input logic [31:0] v, input logic [31:0] exp);
        wait_notify(1);
        b_in2 = v;
        b_in_sync2 = 1'b1;
        model_commit(1, v);
        @(negedge clk);
        chk("gap_data", m_out2, exp);
        chk("gap_sync_t1", {31'd0, sync2}, 32'd1);
        chk("gap_notify_t1", {31'd0, notify2}, 32'd0);
        b_in_sync2 = 1'b0;
        @(negedge clk);
        chk("gap_sync_t2", {31'd0, sync2}, 32'd0);
        chk("gap_notify_t2", {31'd0, notify2}, 32'd0);
        b_in2 = $urandom;
        b_in_sync2 = 1'b1;
        @(negedge clk);
        chk("gap_notify_t3", {31'd0, notify2}, 32'd0);
        chk("gap_sync_t3", {31'd0, sync2}, 32'd0);
        chk("gap_ignored", m_out2, exp);
        b_in_sync2 = 1'b0;
        @(negedge clk);
        chk("gap_notify_t4", {31'd0, notify2}, 32'd1);
        chk("gap_hold_t4", m_out2, exp);
    endtask

    initial begin
        logic [31:0] v;
        model_reset();

        // Reset held with live samples on the inputs.
        b_in0 = 32'h1234_5678;
        b_in2 = 32'hdead_beef;
        b_in_sync0 = 1'b1;
        b_in_sync2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_notify0", {31'd0, notify0}, 32'd1);
        chk("rst_m_out0", m_out0, 32'd0);
        chk("rst_sync0", {31'd0, sync0}, 32'd0);
        chk("rst_notify2", {31'd0, notify2}, 32'd1);
        chk("rst_m_out2", m_out2, 32'd0);
        chk("rst_sync2", {31'd0, sync2}, 32'd0);
        b_in_sync0 = 1'b0;
        b_in_sync2 = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Accumulate, frame boundary, and signed wrap.
        send0(32'd5, 32'd5);
        send0(-32'sd3, 32'd2);
        send0(32'd10, 32'd12);
        send0(32'd0, 32'd12);
        send0(32'd1, 32'd1);
        send0(32'd1, 32'd2);
        send0(32'd1, 32'd3);
        send0(32'd1, 32'd4);
        send0(32'd7, 32'd7);
        send0(32'd0, 32'd7);
        send0(32'd0, 32'd7);
        send0(32'd0, 32'd7);
        send0(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        send0(32'd1, 32'h8000_0000);

        // Randomized samples with random idle stretches.
        for (int i = 0; i < 30; i++) begin
            v = $urandom;
            send0(v, model_sum(0, v));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b_in0 = $urandom;
                @(negedge clk);
                chk("idle_sync0", {31'd0, sync0}, 32'd0);
            end
        end

        // FRAME_LEN=1, GAP=2 instance.
        send2(32'd42, 32'd42);
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            send2(v, model_sum(1, v));
        end

        // Reset while a publish pulse is on the output.
        wait_notify(0);
        b_in0 = 32'd3;
        b_in_sync0 = 1'b1;
        @(negedge clk);
        b_in_sync0 = 1'b0;
        chk("midrst_pre_sync", {31'd0, sync0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_sync", {31'd0, sync0}, 32'd0);
        chk("midrst_m_out", m_out0, 32'd0);
        chk("midrst_notify", {31'd0, notify0}, 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send0(32'd9, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tms6_accumulating_producer.md
# tms6_accumulating_producer

Upstream producer for the TestMasterSlave6 slave-in consumer. Takes integer samples over a blocking input port, keeps a running signed sum over a frame of FRAME_LEN samples, and publishes each new partial sum as a one-cycle sync pulse with a data word. Its output port connects directly to the consumer's slave-in port: m_out drives s_in and m_out_sync drives s_in_sync.

## Interface
- FRAME_LEN, 4: samples per frame; the accumulator clears after the last one. Range 1..255.
- GAP, 0: idle cycles inserted after each publish before a new sample is accepted. Range 0..255.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- b_in  in  32  signed sample (integer).
- b_in_sync  in  1  the source has a valid sample on b_in.
- b_in_notify  out  1  the block is ready to take a sample.
- m_out  out  32  signed partial sum (integer). Goes to the consumer's s_in.
- m_out_sync  out  1  one-cycle pulse marking m_out as new. Goes to the consumer's s_in_sync.

## Operation
- A transfer happens on any posedge where b_in_notify=1 and b_in_sync=1.
- FSM states (enum ProdSections): prod_read, prod_write, prod_gap. All outputs are registered.
- Reset values: section=prod_read, b_in_notify=1, m_out=0, m_out_sync=0, acc=0, cnt=0, gap_cnt=0.
- **prod_read**
  - b_in_notify=1.
  - On a transfer: sum = acc + b_in, wrapping mod 2^32 (two's complement, no saturation).
  - Set m_out<=sum, m_out_sync<=1, b_in_notify<=0, section<=prod_write.
  - If cnt==FRAME_LEN-1: cnt<=0 and acc<=0. Otherwise: cnt<=cnt+1 and acc<=sum.
  - With no transfer, all state holds.
- **prod_write**
  - m_out_sync is high for this cycle only. Next edge: m_out_sync<=0.
  - If GAP==0: section<=prod_read and b_in_notify<=1.
  - Otherwise: section<=prod_gap and gap_cnt<=GAP-1.
- **prod_gap**
  - If gap_cnt==0: section<=prod_read and b_in_notify<=1. Otherwise gap_cnt decrements.
- b_in_sync is ignored outside prod_read.
- m_out holds its last value until the next transfer.
- The block never back-pressures on the output side. The consumer must sample m_out on the m_out_sync pulse.

## Timing
- A transfer sampled at edge t gives m_out and m_out_sync=1 valid in cycle t+1. Latency is 1.
- b_in_notify returns high in cycle t+2+GAP.
- Peak throughput is one sample per 2+GAP cycles.
- m_out_sync is never high on two consecutive cycles.
- FRAME_LEN=1 means every published value equals the current sample.
- When a source asserts b_in_sync while b_in_notify is low, it must hold b_in and b_in_sync. No transfer occurs until notify rises.
- Reset mid-operation asynchronously forces every register to its reset value. A pulse in progress is dropped, and no partial frame survives.

## Structure
- The ProdSections enum goes in the shared package testmasterslave6_types, next to the consumer's Sections.
- The FRAME_LEN and GAP range checks are elaboration-time assertions.
- Single module, no sub-module. The gap counter is too small to split out.

## Test plan
- Reset: hold rst high with samples driven. Required: b_in_notify=1, m_out=0, m_out_sync=0.
- Accumulate (FRAME_LEN=4, GAP=0): send 5, −3, 10. Required: m_out = 5, 2, 12, each with a one-cycle m_out_sync one cycle after its transfer, and b_in_notify low exactly one cycle between transfers.
- Frame boundary (FRAME_LEN=4): send 1, 1, 1, 1, 7. Required: m_out = 1, 2, 3, 4, 7.
- Wrap: send 0x7FFFFFFF then 1 in the same frame. Required: m_out = 0x7FFFFFFF, then 0x80000000.
- Gap (GAP=2): capture at t. Required: b_in_notify low in t+1..t+3 and high at t+4. A b_in_sync pulse during t+2 is ignored and m_out is unchanged.
- Reset mid-write: assert rst while m_out_sync=1. Required: m_out_sync=0 and m_out=0 immediately. After release, send 9 and require m_out=9.
